clint: RTL and testbench

// - Memory-mapped core-local interruptor; the responder on the CPU data bus for window clint_base_addr..clint_top_addr.
// - Holds msip, 64-bit mtimecmp and 64-bit mtime; mtime advances on a divided RTC tick.
// - Drives machine software/timer interrupt lines to the core CSR unit.

---
 rtl/clint_pkg.sv | 15 +
 rtl/clint_rtc.sv | 31 +++
 rtl/clint.sv | 93 +++++++++
 tb/tb_clint.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared constants and helpers for the core-local interruptor (CLINT_MTIME_WRITE_EN selects writable mtime)
package clint_pkg;

    localparam int unsigned clk_divider_rtc    = 1;
    localparam logic [15:0] clint_msip_off     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
    localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] wstrb);
        merge_bytes = old;
        for (int i = 0; i < 4; i++)
            if (wstrb[i]) merge_bytes[8*i +: 8] = wdata[8*i +: 8];
    endfunction

endpackage

// File: rtl/clint_rtc.sv
// clint_rtc: divides clock into a slow rtc square wave and emits a one-cycle tick per rtc rising edge
module clint_rtc
    import clint_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER_RTC = clk_divider_rtc
) (
    input  logic clock,
    input  logic reset,
    output logic rtc_tick
);

    logic [31:0] count;
    logic        rtc;
    logic        rtc_q;

    // half-period counter toggles rtc on wrap; tick is registered rising-edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            rtc      <= 1'b0;
            rtc_q    <= 1'b0;
            rtc_tick <= 1'b0;
        end else begin
            count    <= (count == CLK_DIVIDER_RTC) ? '0 : count + 32'd1;
            rtc      <= (count == CLK_DIVIDER_RTC) ? ~rtc : rtc;
            rtc_q    <= rtc;
            rtc_tick <= rtc & ~rtc_q;
        end
    end

endmodule

// File: rtl/clint.sv
// clint: memory-mapped msip/mtimecmp/mtime responder driving machine interrupts; define CLINT_MTIME_WRITE_EN to make mtime writable
module clint
    import clint_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER_RTC = clk_divider_rtc
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    logic        rtc_tick;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_next;
    logic [31:0] rd_data;
    logic        wr;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mtime_lo;
    logic        sel_mtime_hi;
    logic        mtime_wr_lo;
    logic        mtime_wr_hi;
    logic        unused_addr;

    clint_rtc #(.CLK_DIVIDER_RTC(CLK_DIVIDER_RTC)) u_rtc (
        .clock    (clock),
        .reset    (reset),
        .rtc_tick (rtc_tick)
    );

    assign unused_addr  = ^{clint_addr[31:16], clint_addr[1:0]};
    assign wr           = clint_valid & ~clint_instr & (|clint_wstrb);
    assign sel_msip     = clint_addr[15:2] == clint_msip_off[15:2];
    assign sel_cmp_lo   = clint_addr[15:2] == clint_mtimecmp_off[15:2];
    assign sel_cmp_hi   = clint_addr[15:2] == clint_mtimecmp_off[15:2] + 14'd1;
    assign sel_mtime_lo = clint_addr[15:2] == clint_mtime_off[15:2];
    assign sel_mtime_hi = clint_addr[15:2] == clint_mtime_off[15:2] + 14'd1;

`ifdef CLINT_MTIME_WRITE_EN
    assign mtime_wr_lo = wr & sel_mtime_lo;
    assign mtime_wr_hi = wr & sel_mtime_hi;
`else
    assign mtime_wr_lo = 1'b0;
    assign mtime_wr_hi = 1'b0;
`endif

    // read mux over current register state; unmapped offsets read as zero
    always_comb begin
        rd_data = sel_msip     ? {31'd0, clint_msip} :
                  sel_cmp_lo   ? mtimecmp[31:0]      :
                  sel_cmp_hi   ? mtimecmp[63:32]     :
                  sel_mtime_lo ? clint_mtime[31:0]   :
                  sel_mtime_hi ? clint_mtime[63:32]  : 32'd0;
    end

    // a bus write to an mtime half overrides the rtc increment for that cycle
    always_comb begin
        mtime_next = mtime_wr_lo ? {clint_mtime[63:32], merge_bytes(clint_mtime[31:0], clint_wdata, clint_wstrb)} :
                     mtime_wr_hi ? {merge_bytes(clint_mtime[63:32], clint_wdata, clint_wstrb), clint_mtime[31:0]} :
                     rtc_tick    ? clint_mtime + 64'd1 : clint_mtime;
    end

    // bus response, register file and registered timer compare
    always_ff @(posedge clock) begin
        if (reset) begin
            clint_rdata <= '0;
            clint_ready <= 1'b0;
            clint_msip  <= 1'b0;
            clint_mtip  <= 1'b0;
            clint_mtime <= '0;
            mtimecmp    <= '1;
        end else begin
            clint_ready <= clint_valid;
            clint_rdata <= clint_valid ? rd_data : 32'd0;
            if (wr && sel_msip && clint_wstrb[0]) clint_msip <= clint_wdata[0];
            if (wr && sel_cmp_lo) mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], clint_wdata, clint_wstrb);
            if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], clint_wdata, clint_wstrb);
            clint_mtime <= mtime_next;
            clint_mtip  <= clint_mtime >= mtimecmp;
        end
    end

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed self-checking bench for clint with CLK_DIVIDER_RTC=1
module tb_clint;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clint_valid = 1'b0;
    logic        clint_instr = 1'b0;
    logic [31:0] clint_addr = '0;
    logic [31:0] clint_wdata = '0;
    logic [3:0]  clint_wstrb = '0;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;
    int          total = 0;
    int          passed = 0;
    logic [31:0] rd;
    logic        found;

    clint #(.CLK_DIVIDER_RTC(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic f, output logic [31:0] r);
        @(negedge clock);
        clint_valid = 1'b1;
        clint_instr = f;
        clint_addr  = a;
        clint_wdata = d;
        clint_wstrb = s;
        @(posedge clock);
        #1;
        check("ready", {63'd0, clint_ready}, 64'd1);
        r = clint_rdata;
        clint_valid = 1'b0;
        clint_instr = 1'b0;
        clint_wstrb = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {63'd0, clint_ready}, 64'd0);
        check("rst_rdata", {32'd0, clint_rdata}, 64'd0);
        check("rst_msip", {63'd0, clint_msip}, 64'd0);
        check("rst_mtip", {63'd0, clint_mtip}, 64'd0);
        check("rst_mtime", clint_mtime, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        bus(32'h0000, 0, 4'h0, 1'b0, rd);
        check("rd_msip", {32'd0, rd}, 64'd0);
        @(posedge clock);
        #1;
        check("ready_drop", {63'd0, clint_ready}, 64'd0);
        bus(32'h4000, 0, 4'h0, 1'b0, rd);
        check("rd_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
        bus(32'h4004, 0, 4'h0, 1'b0, rd);
        check("rd_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        check("mtip_idle", {63'd0, clint_mtip}, 64'd0);
        bus(32'h1234, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
        check("unmapped_wr", {32'd0, rd}, 64'd0);
        bus(32'h1234, 0, 4'h0, 1'b0, rd);
        check("unmapped_rd", {32'd0, rd}, 64'd0);
        bus(32'h4000, 32'h0000_00AA, 4'b0001, 1'b0, rd);
        check("wr_old_data", {32'd0, rd}, 64'hFFFF_FFFF);
        bus(32'h4000, 0, 4'h0, 1'b0, rd);
        check("cmp_strobe", {32'd0, rd}, 64'hFFFF_FFAA);
        bus(32'h0000, 32'd1, 4'b0001, 1'b0, rd);
        check("msip_set", {63'd0, clint_msip}, 64'd1);
        bus(32'h0000, 32'd0, 4'b0010, 1'b0, rd);
        check("msip_strobe", {63'd0, clint_msip}, 64'd1);
        bus(32'h0000, 32'd0, 4'hF, 1'b1, rd);
        check("msip_fetch", {63'd0, clint_msip}, 64'd1);
        bus(32'h0000, 0, 4'h0, 1'b0, rd);
        check("rd_msip1", {32'd0, rd}, 64'd1);
        bus(32'h0000, 32'd0, 4'b0001, 1'b0, rd);
        check("msip_clr", {63'd0, clint_msip}, 64'd0);

        do_reset();
        repeat (39) @(posedge clock);
        #1;
        check("mtime_39", clint_mtime, 64'd9);
        @(posedge clock);
        #1;
        check("mtime_40", clint_mtime, 64'd10);

        do_reset();
        bus(32'h4004, 32'd0, 4'hF, 1'b0, rd);
        bus(32'h4000, 32'd5, 4'hF, 1'b0, rd);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock);
            #1;
            if (clint_mtime == 64'd5) begin
                found = 1'b1;
                check("mtip_at5", {63'd0, clint_mtip}, 64'd0);
                @(posedge clock);
                #1;
                check("mtip_rise", {63'd0, clint_mtip}, 64'd1);
            end
        end
        check("mtime_reach5", {63'd0, found}, 64'd1);

        bus(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
        bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
`ifdef CLINT_MTIME_WRITE_EN
        check("mtime_wr", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clock);
            #1;
            found = clint_mtime != 64'hFFFF_FFFF_FFFF_FFFF;
        end
        check("mtime_wrap", clint_mtime, 64'd0);
        @(posedge clock);
        #1;
        check("mtip_wrap", {63'd0, clint_mtip}, 64'd0);
`else
        check("mtime_ro_hi", {32'd0, clint_mtime[63:32]}, 64'd0);
        check("mtime_ro_lo", {63'd0, clint_mtime[31:0] < 32'd64}, 64'd1);
        bus(32'hBFFC, 0, 4'h0, 1'b0, rd);
        check("rd_mtime_hi", {32'd0, rd}, 64'd0);
`endif

        @(negedge clock);
        clint_valid = 1'b1;
        clint_addr  = 32'h0000;
        reset       = 1'b1;
        @(posedge clock);
        #1;
        clint_valid = 1'b0;
        check("rst_req_ready0", {63'd0, clint_ready}, 64'd0);
        @(posedge clock);
        #1;
        check("rst_req_ready1", {63'd0, clint_ready}, 64'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
